// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if: client-side req/ack bundle for the
// shared-stack arbiter (push/pop requests and pop results).
interface stack_arbiter_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8
);
  logic [N-1:0]        req;
  logic [N-1:0]        op;
  logic [N*DATA_W-1:0] wdata;
  logic [N-1:0]        ack;
  logic [N-1:0]        err;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output req, op, wdata,
    input  ack, err, rdata
  );

  modport slave (
    input  req, op, wdata,
    output ack, err, rdata
  );
endinterface

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter serialising N push/pop
// clients onto one LIFO stack port, with per-op error flag.
module stack_arbiter #(
  parameter int N      = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  stack_arbiter_if.slave    cli,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_push_data,
  input  logic [DATA_W-1:0] stk_pop_data,
  input  logic              stk_empty,
  input  logic              stk_full
);
  localparam int IW = $clog2(N);

  typedef enum logic {ARB, DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     win, idx;
  logic              found;
  logic              win_op;
  logic              legal;
  logic [N-1:0]      win_oh;
  logic [N-1:0]      ack_q, err_q;
  logic [DATA_W-1:0] rdata_q;

  // pick the first requester after last_grant, wrapping
  always_comb begin
    win   = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_grant) + k) % N);
      if (!found && cli.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign win_op = cli.op[win];
  assign legal  = win_op ? !stk_full : !stk_empty;
  assign win_oh = N'(1) << win;

  // next state and combinational stack strobes
  always_comb begin
    state_nxt     = state;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_push_data = '0;
    unique case (state)
      ARB: begin
        if (found) begin
          state_nxt = DONE;
          if (legal && !reset) begin
            stk_push = win_op;
            stk_pop  = !win_op;
            if (win_op)
              stk_push_data =
                cli.wdata[int'(win)*DATA_W +: DATA_W];
          end
        end
      end
      DONE: state_nxt = ARB;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  // grant pointer and registered completion outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= IW'(N - 1);
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      if (state == ARB && found) begin
        last_grant <= win;
        ack_q      <= win_oh;
        err_q      <= legal ? '0 : win_oh;
        if (!win_op && legal)
          rdata_q <= stk_pop_data;
      end
    end
  end

  assign cli.ack   = ack_q;
  assign cli.err   = err_q;
  assign cli.rdata = rdata_q;
endmodule
